// File: rtl/minimig_autoconfig_chain.sv
// Zorro II/III autoconfig chain: presents one enabled board at a time in the
// autoconfig window. Define AUTOCONFIG_Z3_EN to support Zorro III boards.
module minimig_autoconfig_chain #(
  parameter int          NUM_BOARDS = 6,
  parameter logic [31:0] SERIAL     = 32'h0000_0000,
  parameter int          IDXW       = (NUM_BOARDS > 1) ? $clog2(NUM_BOARDS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk7_en,
  input  logic [7:0]              address_in,
  input  logic [15:0]             data_in,
  output logic [15:0]             data_out,
  input  logic                    rd,
  input  logic                    hwr,
  input  logic                    lwr,
  input  logic                    sel,
  input  logic [NUM_BOARDS-1:0]   board_enable,
  input  logic [NUM_BOARDS-1:0]   board_z3,
  input  logic [NUM_BOARDS-1:0]   board_mem,
  input  logic [4*NUM_BOARDS-1:0] board_size,
  input  logic [8*NUM_BOARDS-1:0] board_product,
  input  logic [16*NUM_BOARDS-1:0] board_mfr,
  output logic [NUM_BOARDS-1:0]   board_configured,
  output logic [NUM_BOARDS-1:0]   board_shutup,
  output logic [16*NUM_BOARDS-1:0] board_base,
  output logic [IDXW-1:0]         current_board,
  output logic                    autoconfig_done
);

`ifdef AUTOCONFIG_Z3_EN
  localparam bit Z3_EN = 1'b1;
`else
  localparam bit Z3_EN = 1'b0;
`endif

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_BOARDS - 1);

  typedef enum logic [1:0] {INIT, SCAN, PRESENT, DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic [IDXW-1:0] idx;
  logic [IDXW-1:0] idx_next;

  logic [NUM_BOARDS-1:0] en_q;
  logic [NUM_BOARDS-1:0] z3_q;
  logic [NUM_BOARDS-1:0] mem_q;
  logic [3:0]            size_q [NUM_BOARDS];
  logic [7:0]            prod_q [NUM_BOARDS];
  logic [15:0]           mfr_q  [NUM_BOARDS];
  logic [15:0]           base_q [NUM_BOARDS];
  logic [NUM_BOARDS-1:0] configured_q;
  logic [NUM_BOARDS-1:0] shutup_q;

  logic        wr_event;
  logic [8:0]  byte_addr;
  logic        set_cfg;
  logic        set_shut;
  logic [15:0] new_base;
  logic        chained;
  logic [7:0]  reg_val;
  logic [3:0]  nibble;
  logic        unused_rd;

  assign wr_event  = clk7_en & sel & (hwr | lwr);
  assign byte_addr = {address_in, 1'b0};
  assign unused_rd = rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    set_cfg    = 1'b0;
    set_shut   = 1'b0;
    new_base   = 16'h0000;
    unique case (state)
      INIT: begin
        state_next = SCAN;
        idx_next   = '0;
      end
      SCAN: begin
        if (en_q[idx]) begin
          state_next = PRESENT;
        end else if (idx == LAST_IDX) begin
          state_next = DONE;
        end else begin
          idx_next = idx + 1'b1;
        end
      end
      PRESENT: begin
        if (wr_event) begin
          if (byte_addr == 9'h048 && !z3_q[idx]) begin
            set_cfg  = 1'b1;
            new_base = {8'h00, data_in[15:8]};
          end else if (Z3_EN && byte_addr == 9'h044 && z3_q[idx]) begin
            set_cfg  = 1'b1;
            new_base = data_in;
          end else if (byte_addr == 9'h04C) begin
            set_shut = 1'b1;
          end
          if (set_cfg || set_shut) begin
            if (idx == LAST_IDX) begin
              state_next = DONE;
            end else begin
              idx_next   = idx + 1'b1;
              state_next = SCAN;
            end
          end
        end
      end
      DONE: begin
        state_next = DONE;
      end
      default: begin
        state_next = INIT;
      end
    endcase
  end

  // Board configuration is frozen at INIT so the chain cannot shift mid-walk.
  // Without Zorro III support such boards are dropped from the chain entirely.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q  <= '0;
      z3_q  <= '0;
      mem_q <= '0;
      for (int i = 0; i < NUM_BOARDS; i++) begin
        size_q[i] <= 4'h0;
        prod_q[i] <= 8'h00;
        mfr_q[i]  <= 16'h0000;
      end
    end else if (state == INIT) begin
      mem_q <= board_mem;
`ifdef AUTOCONFIG_Z3_EN
      en_q  <= board_enable;
      z3_q  <= board_z3;
`else
      en_q  <= board_enable & ~board_z3;
      z3_q  <= '0;
`endif
      for (int i = 0; i < NUM_BOARDS; i++) begin
        size_q[i] <= board_size[4*i +: 4];
        prod_q[i] <= board_product[8*i +: 8];
        mfr_q[i]  <= board_mfr[16*i +: 16];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      configured_q <= '0;
      shutup_q     <= '0;
      for (int i = 0; i < NUM_BOARDS; i++) begin
        base_q[i] <= 16'h0000;
      end
    end else begin
      if (set_cfg) begin
        configured_q[idx] <= 1'b1;
        base_q[idx]       <= new_base;
      end
      if (set_shut) begin
        shutup_q[idx] <= 1'b1;
      end
    end
  end

  // Descriptor generator: everything but er_type is stored inverted on the bus.
  always_comb begin
    chained = 1'b0;
    for (int i = 0; i < NUM_BOARDS; i++) begin
      if (i > int'(idx) && en_q[i]) begin
        chained = 1'b1;
      end
    end
    reg_val = 8'h00;
    case (address_in[7:1])
      7'd0: reg_val = {(z3_q[idx] ? 2'b10 : 2'b11), mem_q[idx], 1'b0, chained, size_q[idx][2:0]};
      7'd1: reg_val = ~prod_q[idx];
      7'd2: reg_val = ~{2'b00, size_q[idx][3], z3_q[idx], 4'h0};
      7'd4: reg_val = ~mfr_q[idx][15:8];
      7'd5: reg_val = ~mfr_q[idx][7:0];
      7'd6: reg_val = ~SERIAL[31:24];
      7'd7: reg_val = ~SERIAL[23:16];
      7'd8: reg_val = ~SERIAL[15:8];
      7'd9: reg_val = ~SERIAL[7:0];
      default: reg_val = 8'h00;
    endcase
    nibble = address_in[0] ? reg_val[3:0] : reg_val[7:4];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= 16'h0000;
    end else if (sel) begin
      data_out <= {((state == PRESENT) ? nibble : 4'h0), 12'hfff};
    end else begin
      data_out <= 16'h0000;
    end
  end

  for (genvar g = 0; g < NUM_BOARDS; g++) begin : g_base
    assign board_base[16*g +: 16] = base_q[g];
  end

  assign board_configured = configured_q;
  assign board_shutup     = shutup_q;
  assign current_board    = idx;
  assign autoconfig_done  = (state == DONE);

endmodule

// File: tb/tb_minimig_autoconfig_chain.sv
// Directed self-checking bench for minimig_autoconfig_chain (3-board chain).
module tb_minimig_autoconfig_chain;
  localparam int N    = 3;
  localparam int IDXW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          clk7_en;
  logic [7:0]    address_in;
  logic [15:0]   data_in;
  logic [15:0]   data_out;
  logic          rd;
  logic          hwr;
  logic          lwr;
  logic          sel;
  logic [N-1:0]  board_enable;
  logic [N-1:0]  board_z3;
  logic [N-1:0]  board_mem;
  logic [4*N-1:0]  board_size;
  logic [8*N-1:0]  board_product;
  logic [16*N-1:0] board_mfr;
  logic [N-1:0]  board_configured;
  logic [N-1:0]  board_shutup;
  logic [16*N-1:0] board_base;
  logic [IDXW-1:0] current_board;
  logic          autoconfig_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  minimig_autoconfig_chain #(
    .NUM_BOARDS(N),
    .SERIAL(32'h1234_5678)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clk7_en(clk7_en),
    .address_in(address_in),
    .data_in(data_in),
    .data_out(data_out),
    .rd(rd),
    .hwr(hwr),
    .lwr(lwr),
    .sel(sel),
    .board_enable(board_enable),
    .board_z3(board_z3),
    .board_mem(board_mem),
    .board_size(board_size),
    .board_product(board_product),
    .board_mfr(board_mfr),
    .board_configured(board_configured),
    .board_shutup(board_shutup),
    .board_base(board_base),
    .current_board(current_board),
    .autoconfig_done(autoconfig_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [47:0] observed, input logic [47:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One bus cycle held across exactly one clk edge, then the bus is released.
  task automatic applyStimulus(input logic s, input logic ce, input logic [7:0] a,
                               input logic [15:0] d, input logic h, input logic l);
    sel        = s;
    clk7_en    = ce;
    address_in = a;
    data_in    = d;
    hwr        = h;
    lwr        = l;
    rd         = ~(h | l);
    tick();
    sel = 1'b0;
    hwr = 1'b0;
    lwr = 1'b0;
    rd  = 1'b0;
  endtask

  task automatic readNibble(input logic [7:0] a, input logic [3:0] nib, input string tag);
    applyStimulus(1'b1, 1'b1, a, 16'h0000, 1'b0, 1'b0);
    checkOutput(tag, data_out, {nib, 12'hfff});
  endtask

  task automatic startChain(input logic [N-1:0] en, input logic [N-1:0] z3);
    board_enable = en;
    board_z3     = z3;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; clk7_en = 1'b1; address_in = 8'h00; data_in = 16'h0000;
    rd = 1'b0; hwr = 1'b0; lwr = 1'b0; sel = 1'b0;
    board_enable  = 3'b111;
    board_z3      = 3'b000;
    board_mem     = 3'b010;
    board_size    = {4'b1000, 4'b0000, 4'b0110};
    board_product = {8'h22, 8'h11, 8'h67};
    board_mfr     = {16'h0A1C, 16'h0A1C, 16'h0A1C};

    $display("[TB] full Z2 chain walk");
    startChain(3'b111, 3'b000);
    checkOutput("reset_data_out", data_out, 16'h0000);
    checkOutput("reset_done", autoconfig_done, 1'b0);
    tick();
    tick();
    checkOutput("b0_current", current_board, 2'd0);
    readNibble(8'h00, 4'hC, "b0_ertype_hi");
    readNibble(8'h01, 4'hE, "b0_ertype_lo");
    readNibble(8'h02, 4'h9, "b0_product_hi");
    readNibble(8'h04, 4'hF, "b0_flags_hi");
    readNibble(8'h09, 4'h5, "b0_mfr_hi_lo");
    readNibble(8'h0B, 4'h3, "b0_mfr_lo_lo");
    readNibble(8'h0C, 4'hE, "b0_serial_first");
    readNibble(8'h13, 4'h7, "b0_serial_last");
    readNibble(8'h14, 4'h0, "b0_reg10");
    applyStimulus(1'b0, 1'b1, 8'h00, 16'h0000, 1'b0, 1'b0);
    checkOutput("unsel_read", data_out, 16'h0000);

    applyStimulus(1'b1, 1'b0, 8'h24, 16'h2000, 1'b1, 1'b0);
    checkOutput("no_clk7_cfg", board_configured, 3'b000);
    checkOutput("no_clk7_idx", current_board, 2'd0);
    applyStimulus(1'b0, 1'b1, 8'h24, 16'h2000, 1'b1, 1'b1);
    checkOutput("no_sel_cfg", board_configured, 3'b000);
    applyStimulus(1'b1, 1'b1, 8'h22, 16'h4000, 1'b1, 1'b1);
    checkOutput("z3_write_on_z2", board_configured, 3'b000);
    applyStimulus(1'b1, 1'b1, 8'h24, 16'h2000, 1'b1, 1'b0);
    checkOutput("b0_cfg", board_configured, 3'b001);
    checkOutput("b0_base", board_base[15:0], 16'h0020);
    checkOutput("b0_advance", current_board, 2'd1);

    tick();
    readNibble(8'h00, 4'hE, "b1_ertype_hi_mem");
    readNibble(8'h01, 4'h8, "b1_ertype_lo");
    applyStimulus(1'b1, 1'b1, 8'h26, 16'hFFFF, 1'b0, 1'b1);
    checkOutput("b1_shutup", board_shutup, 3'b010);
    checkOutput("b1_base_zero", board_base[31:16], 16'h0000);
    checkOutput("b1_cfg_kept", board_configured, 3'b001);
    checkOutput("b1_advance", current_board, 2'd2);

    tick();
    readNibble(8'h01, 4'h0, "b2_unchained");
    readNibble(8'h04, 4'hD, "b2_flags_size3");
    applyStimulus(1'b1, 1'b1, 8'h24, 16'hAB00, 1'b1, 1'b1);
    checkOutput("b2_done", autoconfig_done, 1'b1);
    checkOutput("b2_cfg", board_configured, 3'b101);
    checkOutput("b2_base", board_base[47:32], 16'h00AB);
    readNibble(8'h00, 4'h0, "done_no_board");
    applyStimulus(1'b1, 1'b1, 8'h26, 16'h0000, 1'b1, 1'b1);
    checkOutput("done_write_ignored", board_shutup, 3'b010);

    $display("[TB] reset while presenting board 1");
    startChain(3'b111, 3'b000);
    tick();
    tick();
    applyStimulus(1'b1, 1'b1, 8'h24, 16'h2000, 1'b1, 1'b0);
    tick();
    board_size[3:0] = 4'b0011;
    reset = 1'b1;
    sel = 1'b1;
    address_in = 8'h00;
    tick();
    checkOutput("rst_cfg", board_configured, 3'b000);
    checkOutput("rst_base", board_base, 48'h0);
    checkOutput("rst_shutup", board_shutup, 3'b000);
    checkOutput("rst_idx", current_board, 2'd0);
    checkOutput("rst_data_out", data_out, 16'h0000);
    reset = 1'b0;
    sel = 1'b0;
    tick();
    tick();
    readNibble(8'h01, 4'hB, "rst_new_size");

    $display("[TB] sparse chain");
    startChain(3'b100, 3'b000);
    tick();
    tick();
    tick();
    checkOutput("sparse_idx", current_board, 2'd2);
    checkOutput("sparse_not_done", autoconfig_done, 1'b0);
    tick();
    readNibble(8'h01, 4'h0, "sparse_lo");
    readNibble(8'h00, 4'hC, "sparse_hi");

    $display("[TB] empty chain");
    startChain(3'b000, 3'b000);
    n = 0;
    while (!autoconfig_done && n < 20) begin
      tick();
      n++;
    end
    checkOutput("empty_latency", n, 4);

`ifdef AUTOCONFIG_Z3_EN
    $display("[TB] Zorro III board");
    startChain(3'b001, 3'b001);
    tick();
    tick();
    readNibble(8'h00, 4'h8, "z3_ertype_hi");
    readNibble(8'h04, 4'hE, "z3_flags_hi");
    applyStimulus(1'b1, 1'b1, 8'h24, 16'h2000, 1'b1, 1'b1);
    checkOutput("z3_ignore_48", board_configured, 3'b000);
    applyStimulus(1'b1, 1'b1, 8'h22, 16'h4000, 1'b1, 1'b1);
    checkOutput("z3_cfg", board_configured, 3'b001);
    checkOutput("z3_base", board_base[15:0], 16'h4000);
`else
    $display("[TB] Zorro III board skipped");
    startChain(3'b011, 3'b001);
    tick();
    tick();
    checkOutput("z3_skip_idx", current_board, 2'd1);
    tick();
    applyStimulus(1'b1, 1'b1, 8'h22, 16'h4000, 1'b1, 1'b1);
    checkOutput("z3_44_ignored", board_configured, 3'b000);
    applyStimulus(1'b1, 1'b1, 8'h24, 16'h5500, 1'b1, 1'b1);
    checkOutput("z3_skip_cfg", board_configured, 3'b010);
    checkOutput("z3_skip_base", board_base[31:16], 16'h0055);
    tick();
    checkOutput("z3_skip_done", autoconfig_done, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/minimig_autoconfig_chain.md
# minimig_autoconfig_chain

Parametrised Zorro II/III autoconfig chain controller for up to NUM_BOARDS expansion boards. Replaces fixed per-board descriptor ROMs with a descriptor generator built from per-board configuration buses. It presents one board at a time in the 0xE80000 autoconfig window, captures the base address or shut-up command for that board, and advances to the next enabled board. It sits between the CPU address decoder (sel) and the fast-RAM/peripheral decoders, which consume `board_base` and `board_configured`.

## Interface
- NUM_BOARDS, 6: chain length, 1..8; board 0 is presented first.
- SERIAL, 32'h0000_0000: serial number reported by every board.
- IDXW, $clog2(NUM_BOARDS) (min 1): width of board index.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- clk7_en  in  1  CPU bus qualifier; all write events require it.
- address_in  in  8  CPU address [8:1] within the autoconfig window.
- data_in  in  16  CPU write data.
- data_out  out  16  read data; nibble in [15:12], [11:0] = 12'hfff when sel, 16'h0000 otherwise.
- rd, hwr, lwr  in  1 each  CPU read, high-byte write, low-byte write.
- sel  in  1  autoconfig window selected.
- board_enable  in  N  board present in chain.
- board_z3  in  N  1 = Zorro III board, 0 = Zorro II.
- board_mem  in  N  board is memory (er_type bit 5).
- board_size  in  4N  size code; [2:0] to er_type, [3] to er_flags bit 5.
- board_product  in  8N  product ID.
- board_mfr  in  16N  manufacturer ID.
- board_configured  out  N  board accepted a base address.
- board_shutup  out  N  board was shut up.
- board_base  out  16N  captured base: Z2 = {8'h00, A23:16}, Z3 = A31:16.
- current_board  out  IDXW  index being presented.
- autoconfig_done  out  1  chain exhausted.

## Operation
- States: INIT, SCAN, PRESENT, DONE. Reset forces INIT from any state, mid-transaction included.
- INIT, one clk: latch board_enable, board_z3, board_mem, board_size, board_product, and board_mfr into internal copies, which are used until the next reset. Set idx=0 and go to SCAN.
- SCAN, one board per clk: if idx is enabled, go to PRESENT. Otherwise idx+1. If idx = NUM_BOARDS-1 and that board is not enabled, go to DONE.
- PRESENT: the descriptor of board idx is readable, and writes are decoded on byte address {address_in,1'b0}:
  - 0x48 on a Z2 board: base = data_in[15:8], set configured[idx], idx+1 and go to SCAN (DONE if idx is the last board).
  - 0x44 on a Z3 board: base = data_in[15:0], set configured[idx], advance as above.
  - 0x4C on any board: set shutup[idx], base unchanged, advance as above.
  - 0x48 on a Z3 board, 0x44 on a Z2 board, and all other offsets are ignored.
- A write event is clk7_en & sel & (hwr|lwr). hwr and lwr asserted together count as one event.
- Descriptor registers: register n occupies byte offsets 4n (high nibble) and 4n+2 (low nibble).
  - Reg 0, er_type, not inverted: {z3?2'b10:2'b11, mem, 1'b0, chained, size[2:0]}. chained=1 iff an enabled board exists at a higher index.
  - Reg 1, product, inverted.
  - Reg 2, er_flags, inverted: {1'b0,1'b0,size[3],z3,4'h0}.
  - Regs 4-5: mfr high byte, then mfr low byte, inverted.
  - Regs 6-9: SERIAL, MSB first, inverted.
  - Regs 10 and above read nibble 0.
- In SCAN, DONE, and INIT, the read nibble is 0, so the host sees "no board".
- autoconfig_done=1 only in DONE. current_board = idx.
- Reset values: data_out=0, board_configured=0, board_shutup=0, board_base=0, current_board=0, autoconfig_done=0.

## Timing
- data_out is registered: it reflects sel and address_in sampled at the previous clk edge, with 1 clk latency and independent of clk7_en and rd.
- A write event is acted on at the clk edge where it is sampled. The configured or shutup bit and board_base are visible on the next cycle.
- After the last board is handled, autoconfig_done asserts 1 clk later if no enabled board follows. Otherwise it asserts after the SCAN walk, which takes at most NUM_BOARDS clks.
- No enabled boards: autoconfig_done asserts at most NUM_BOARDS+1 clks after reset deasserts.
- Writes arriving during SCAN, INIT, or DONE are ignored.

## Configuration
- AUTOCONFIG_Z3_EN defined: Zorro III boards are supported as described above.
- AUTOCONFIG_Z3_EN undefined:
  - board_z3 is treated as 0 for disabled boards and forces boards with board_z3=1 to be skipped in SCAN, as if not enabled.
  - 0x44 writes are always ignored.
  - er_flags bit 4 is always 0.

## Test plan
- N=3, all enabled Z2, product 8'h67 and mfr 16'h0A1C on board 0 → read 0x00 gives 0xC, 0x02 gives 0xE, 0x04 gives ~6 = 0x9; write 0x48 data 16'h2000 → board_base[15:0]=16'h0020, configured[0]=1, current_board=1.
- board_enable=3'b100 → two SCAN clks, then PRESENT board 2 with chained=0 (read 0x02 gives 0x0 when size 0).
- Z3 board 0 (requires AUTOCONFIG_Z3_EN): write 0x48 is ignored; write 0x44 data 16'h4000 → base 16'h4000, configured[0]=1.
- Shut-up write 0x4C on the last board → shutup set, base 0, autoconfig_done=1 on the next clk, and reads return data_out=16'h0fff.
- Reset asserted while in PRESENT for board 1 → all outputs clear. After reset deasserts, board 0 is presented with newly latched board_size.
- Write without clk7_en, or with sel=0 → no state change.
